// File: rtl/rggen_apb_register_adapter.sv
//==============================================================================
// Module   : rggen_apb_register_adapter
// Brief    : APB3/APB4 slave front-end that converts host transfers into the
//            internal register-bus handshake. Optional watchdog guarded by
//            RGGEN_APB_ADAPTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rggen_apb_register_adapter #(
  parameter int                   ADDRESS_WIDTH       = 16,
  parameter int                   LOCAL_ADDRESS_WIDTH = 8,
  parameter int                   BUS_WIDTH           = 32,
  parameter int                   BASE_ADDRESS        = 0,
  parameter int                   BYTE_SIZE           = 256,
  parameter bit                   ERROR_STATUS        = 1'b0,
  parameter logic [BUS_WIDTH-1:0] DEFAULT_READ_DATA   = '0,
  parameter int                   TIMEOUT_CYCLES      = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
  input  logic [2:0]                     i_pprot,
  input  logic                           i_pwrite,
  input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
  input  logic [BUS_WIDTH-1:0]           i_pwdata,
  output logic                           o_pready,
  output logic [BUS_WIDTH-1:0]           o_prdata,
  output logic                           o_pslverr,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic                           i_register_active,
  input  logic                           i_register_ready,
  input  logic [1:0]                     i_register_status,
  input  logic [BUS_WIDTH-1:0]           i_register_read_data
);

  localparam int c_strb_width = BUS_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH:0] c_base  = (ADDRESS_WIDTH+1)'(BASE_ADDRESS);
  localparam logic [ADDRESS_WIDTH:0] c_limit = (ADDRESS_WIDTH+1)'(BASE_ADDRESS + BYTE_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                           r_state;
  logic                             r_valid;
  logic                             r_pready;
  logic                             r_pslverr;
  logic [BUS_WIDTH-1:0]             r_prdata;
  logic                             r_write;
  logic [LOCAL_ADDRESS_WIDTH-1:0]   r_address;
  logic [BUS_WIDTH-1:0]             r_strobe;
  logic [BUS_WIDTH-1:0]             r_write_data;

  logic                             w_setup;
  logic                             w_in_range;
  logic [ADDRESS_WIDTH-1:0]         w_offset;
  logic [BUS_WIDTH-1:0]             w_strobe;
  logic                             w_unused;

  assign w_setup    = i_psel && !i_penable;
  assign w_in_range = ({1'b0, i_paddr} >= c_base) && ({1'b0, i_paddr} < c_limit);
  assign w_offset   = i_paddr - c_base[ADDRESS_WIDTH-1:0];

  // Reads present a full mask so read-side decoders never see a partial lane.
  for (genvar g = 0; g < c_strb_width; g++) begin : g_strobe
    assign w_strobe[8*g +: 8] = {8{i_pstrb[g] || !i_pwrite}};
  end

`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
  localparam int c_count_width = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_count_width-1:0] c_count_last = c_count_width'(TIMEOUT_CYCLES - 1);
  logic [c_count_width-1:0] r_count;
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
`endif

  assign w_unused = ^{i_pprot, i_register_status[0], w_offset};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_valid      <= 1'b0;
      r_pready     <= 1'b0;
      r_pslverr    <= 1'b0;
      r_prdata     <= '0;
      r_write      <= 1'b0;
      r_address    <= '0;
      r_strobe     <= '0;
      r_write_data <= '0;
`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
      r_count      <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_write      <= i_pwrite;
            r_address    <= w_offset[LOCAL_ADDRESS_WIDTH-1:0];
            r_strobe     <= w_strobe;
            r_write_data <= i_pwdata;
            if (w_in_range) begin
              r_state <= ST_BUSY;
              r_valid <= 1'b1;
`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
              r_count <= '0;
`endif
            end else begin
              r_state   <= ST_ACK;
              r_pready  <= 1'b1;
              r_prdata  <= DEFAULT_READ_DATA;
              r_pslverr <= ERROR_STATUS;
            end
          end
        end
        ST_BUSY: begin
          if (i_register_active && i_register_ready) begin
            r_state   <= ST_ACK;
            r_valid   <= 1'b0;
            r_pready  <= 1'b1;
            r_prdata  <= r_write ? '0 : i_register_read_data;
            r_pslverr <= i_register_status[1];
          end else if (!i_register_active) begin
            // No register claimed the address: answer as an unmapped hole.
            r_state   <= ST_ACK;
            r_valid   <= 1'b0;
            r_pready  <= 1'b1;
            r_prdata  <= DEFAULT_READ_DATA;
            r_pslverr <= ERROR_STATUS;
          end
`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
          else if (r_count == c_count_last) begin
            r_state   <= ST_ACK;
            r_valid   <= 1'b0;
            r_pready  <= 1'b1;
            r_prdata  <= DEFAULT_READ_DATA;
            r_pslverr <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
`endif
        end
        ST_ACK: begin
          r_state   <= ST_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_valid   <= 1'b0;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end
      endcase
    end
  end

  assign o_pready              = r_pready;
  assign o_prdata              = r_prdata;
  assign o_pslverr             = r_pslverr;
  assign o_register_valid      = r_valid;
  assign o_register_access     = {r_write, 1'b0};
  assign o_register_address    = r_address;
  assign o_register_write_data = r_write_data;
  assign o_register_strobe     = r_strobe;

endmodule

`default_nettype wire
